// File: rtl/seg_pkg.sv
// Shared segment codes and error pattern for the multiplexed 7-segment scanner.
// Codes are 7-bit {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3f;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5b;
  localparam logic [6:0] SEG_3     = 7'h4f;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6d;
  localparam logic [6:0] SEG_6     = 7'h7d;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7f;
  localparam logic [6:0] SEG_9     = 7'h6f;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7c;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5e;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_R     = 7'h77;
  localparam logic [6:0] SEG_O     = 7'h3f;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // "ERROR" spelled on digits 4..0; entries 5..7 pad the array to a power of two
  localparam logic [6:0] ERR_PAT [8] = '{SEG_R, SEG_O, SEG_R, SEG_R, SEG_E,
                                         SEG_BLANK, SEG_BLANK, SEG_BLANK};

endpackage

// File: rtl/seg_decode.sv
// Nibble to 7-segment decoder; letters A-F only when HEX_EN is set.
module seg_decode
  import seg_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] nib,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = SEG_BLANK;
    case (nib)
      4'h0: seg7 = SEG_0;
      4'h1: seg7 = SEG_1;
      4'h2: seg7 = SEG_2;
      4'h3: seg7 = SEG_3;
      4'h4: seg7 = SEG_4;
      4'h5: seg7 = SEG_5;
      4'h6: seg7 = SEG_6;
      4'h7: seg7 = SEG_7;
      4'h8: seg7 = SEG_8;
      4'h9: seg7 = SEG_9;
      4'ha: seg7 = HEX_EN ? SEG_A : SEG_BLANK;
      4'hb: seg7 = HEX_EN ? SEG_B : SEG_BLANK;
      4'hc: seg7 = HEX_EN ? SEG_C : SEG_BLANK;
      4'hd: seg7 = HEX_EN ? SEG_D : SEG_BLANK;
      4'he: seg7 = HEX_EN ? SEG_E : SEG_BLANK;
      4'hf: seg7 = HEX_EN ? SEG_F : SEG_BLANK;
      default: seg7 = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_n.sv
// N-digit multiplexed 7-segment scanner: one digit per tick, scanning from the
// leftmost digit down to digit 0, with blanking, sign, dp, blink and error override.
module seg_scan_n
  import seg_pkg::*;
#(
  parameter int N_DIGIT     = 8,
  parameter bit HEX_EN      = 1'b0,
  parameter int BLINK_TICKS = 250,
  parameter bit COM_ACT_LOW = 1'b0,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_tick,
  input  logic [4*N_DIGIT-1:0]   i_bcd,
  input  logic [N_DIGIT-1:0]     i_dp,
  input  logic [N_DIGIT-1:0]     i_blink,
  input  logic                   i_lzb_en,
  input  logic                   i_neg,
  input  logic                   i_err,
  output logic [7:0]             o_seg_d,
  output logic [N_DIGIT-1:0]     o_seg_com,
  output logic                   o_frame
);

  localparam int SEL_W = $clog2(N_DIGIT);
  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [SEL_W-1:0]   sel;
  logic [CNT_W-1:0]   blink_cnt;
  logic               blink_ph;

  logic [4:0]         sel_x;
  logic [4:0]         msd;
  logic [3:0]         nib_p0;
  logic [6:0]         dec_p0;
  logic               sign_p0;
  logic               en_p0;
  logic               dark_p0;
  logic [6:0]         seg7_p0;
  logic               dp_p0;
  logic [N_DIGIT-1:0] onehot_p0;

  logic [N_DIGIT-1:0] com_p1;
  logic [7:0]         seg_p1;
  logic               frame_p1;

  assign sel_x  = 5'(sel);
  assign nib_p0 = i_bcd[{sel, 2'b00} +: 4];

  seg_decode #(
    .HEX_EN(HEX_EN)
  ) u_dec (
    .nib  (nib_p0),
    .seg7 (dec_p0)
  );

  // Highest non-zero nibble; stays 0 for an all-zero value
  always_comb begin
    msd = '0;
    for (int d = 0; d < N_DIGIT; d++) begin
      if (i_bcd[4*d +: 4] != 4'd0) msd = 5'(d);
    end
  end

  always_comb begin
    onehot_p0 = N_DIGIT'(1) << sel;
    sign_p0   = i_neg && ((msd + 5'd1) < 5'(N_DIGIT)) && (sel_x == (msd + 5'd1));
    dark_p0   = blink_ph && i_blink[sel];
    if (i_err) begin
      en_p0   = (sel_x <= 5'd4);
      seg7_p0 = ERR_PAT[sel_x[2:0]];
      dp_p0   = 1'b0;
    end else begin
      en_p0   = sign_p0 || !i_lzb_en || (sel_x <= msd);
      seg7_p0 = sign_p0 ? SEG_MINUS : dec_p0;
      dp_p0   = i_dp[sel];
    end
  end

  // p0 -> p1: digit outputs registered on the tick, then the scan steps down
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel       <= SEL_W'(N_DIGIT - 1);
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      com_p1    <= '0;
      seg_p1    <= '0;
      frame_p1  <= 1'b0;
    end else begin
      frame_p1 <= 1'b0;
      if (i_tick) begin
        com_p1   <= (en_p0 && !dark_p0) ? onehot_p0 : '0;
        seg_p1   <= en_p0 ? {dp_p0, seg7_p0} : 8'h00;
        frame_p1 <= (sel == '0);
        sel      <= (sel == '0) ? SEL_W'(N_DIGIT - 1) : sel - 1'b1;
        if (blink_cnt == CNT_W'(BLINK_TICKS - 1)) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign o_seg_com = com_p1 ^ {N_DIGIT{COM_ACT_LOW}};
  assign o_seg_d   = seg_p1 ^ {8{SEG_ACT_LOW}};
  assign o_frame   = frame_p1;

endmodule
